// File: rtl/hoaa_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial HOAA add controller.
// Valid/ready: a transfer happens on a rising clk edge where valid & ready are both high;
// the source holds its payload stable and valid high until that edge, and ready never waits on valid.
interface hoaa_serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, op_a, op_b, op_cin, approx_en, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, approx_en, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/hoaa_serial_add_ctrl.sv
// Bit-serial adder controller: one adder cell reused over WIDTH clocks, LSB first.
// The low APPROX_BITS bits may use the HOAA approximate rule; the upper bits are always exact.
module hoaa_serial_add_ctrl #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hoaa_serial_add_ctrl_if.slave       bus,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  // Bit i is approximable when APPROX_MASK[i] is set; APPROX_BITS = 0 gives an all-zero mask.
  localparam logic [WIDTH-1:0] APPROX_MASK = {WIDTH{1'b1}} >> (WIDTH - APPROX_BITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             en_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             in_ready_q;

  logic a_bit;
  logic b_bit;
  logic gated;
  logic approx_bit;
  logic s_bit;
  logic c_next;

  // Single shared adder cell, evaluated on the current bit index.
  always_comb begin
    a_bit      = a_q[idx];
    b_bit      = b_q[idx];
    gated      = a_bit | carry;
    approx_bit = en_q & APPROX_MASK[idx];
    s_bit      = a_bit ^ b_bit ^ carry;
    c_next     = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    if (approx_bit) begin
      s_bit  = gated ^ b_bit;
      c_next = gated & b_bit;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.in_valid && in_ready_q) state_next = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      en_q       <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      // Registered so that in_ready stays low throughout reset and rises one edge later.
      in_ready_q <= (state_next == S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q    <= bus.op_a;
            b_q    <= bus.op_b;
            en_q   <= bus.approx_en;
            carry  <= bus.op_cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        S_RUN: begin
          sum_q[idx] <= s_bit;
          carry      <= c_next;
          if (idx == LAST_IDX) begin
            cout_q <= c_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = (state == S_RUN);
  assign state_dbg     = state;

endmodule

// File: tb/tb_hoaa_serial_add_ctrl.sv
// Directed and random checks of hoaa_serial_add_ctrl at WIDTH = 8, APPROX_BITS = 4.
module tb_hoaa_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] state_dbg;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         acc_cnt  = 0;
  int         out_cnt  = 0;
  logic [8:0] exp_q[$];

  hoaa_serial_add_ctrl_if #(.WIDTH(8)) bus ();

  hoaa_serial_add_ctrl #(.WIDTH(8), .APPROX_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // handshake monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (bus.out_valid && bus.out_ready) out_cnt++;
    end
  end

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic en);
    logic       c;
    logic       g;
    logic [7:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if (en && i < 4) begin
        g    = a[i] | c;
        s[i] = g ^ b[i];
        c    = g & b[i];
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, s};
  endfunction

  // driver: called at a negedge, returns at a negedge with the result consumed
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic en,
                        output logic [7:0] s, output logic co, output int lat, output int busy_cyc);
    int guard;
    s = '0; co = 1'b0; lat = 0; busy_cyc = 0; guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.op_a = a; bus.op_b = b; bus.op_cin = cin; bus.approx_en = en;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a = ~a; bus.op_b = ~b; bus.op_cin = ~cin; bus.approx_en = ~en;
    while (!bus.out_valid && lat < 50) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s  = bus.sum;
    co = bus.cout;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_cin = 1'b0;
    bus.approx_en = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if ({bus.cout, bus.sum} !== 9'h000) begin
      n_fail++; $display("FAIL reset_result got=%h exp=000", {bus.cout, bus.sum});
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic en, input logic [7:0] exp_s, input logic exp_c);
    logic [7:0] s;
    logic       co;
    int         lat;
    int         bc;
    run_op(a, b, cin, en, s, co, lat, bc);
    n_checks++;
    if ({co, s} !== {exp_c, exp_s}) begin
      n_fail++; $display("FAIL %s got cout=%b sum=%h exp cout=%b sum=%h", name, co, s, exp_c, exp_s);
    end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL %s_latency got=%0d exp=8", name, lat); end
  endtask

  task automatic test_approx_add();
    check_op("approx_0f_01", 8'h0F, 8'h01, 1'b0, 1'b1, 8'h0E, 1'b0);
    check_op("exact_0f_01",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
  endtask

  task automatic test_carry_cutoff();
    check_op("exact_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    check_op("approx_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 1'b0);
  endtask

  task automatic test_carry_in();
    logic [7:0] s;
    logic       co;
    int         lat;
    int         bc;
    run_op(8'h00, 8'h03, 1'b1, 1'b1, s, co, lat, bc);
    n_checks++;
    if ({co, s} !== 9'h004) begin n_fail++; $display("FAIL carry_in got=%h exp=004", {co, s}); end
    n_checks++;
    if (bc !== 8) begin n_fail++; $display("FAIL busy_cycles got=%0d exp=8", bc); end
    n_checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_op got in_ready=%b busy=%b exp 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    bus.out_ready = 1'b0;
    bus.op_a = 8'h3C; bus.op_b = 8'h5A; bus.op_cin = 1'b0; bus.approx_en = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.cout, bus.sum} !== 9'h096) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc=%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=096",
                 i, bus.out_valid, bus.in_ready, {bus.cout, bus.sum});
      end
      bus.in_valid = (i == 2);
      bus.op_a = 8'h11; bus.op_b = 8'h22;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.cout, bus.sum} !== 9'h096 || busy !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_ignore got res=%h busy=%b exp res=096 busy=0",
                         {bus.cout, bus.sum}, busy);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release got ir=%b ov=%b exp ir=1 ov=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_ov;
    bus.op_a = 8'h07; bus.op_b = 8'h00; bus.op_cin = 1'b0; bus.approx_en = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b1 || bus.sum !== 8'h07) begin
      n_fail++; $display("FAIL mid_run_progress got busy=%b sum=%h exp busy=1 sum=07", busy, bus.sum);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, bus.in_ready, bus.out_valid, bus.cout, bus.sum} !== 12'h000) begin
      n_fail++; $display("FAIL async_reset got busy=%b ir=%b ov=%b cout=%b sum=%h exp all 0",
                         busy, bus.in_ready, bus.out_valid, bus.cout, bus.sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen_ov++;
    end
    n_checks++;
    if (seen_ov !== 0) begin n_fail++; $display("FAIL aborted_out_valid got=%0d cycles exp=0", seen_ov); end
    check_op("post_reset_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       en;
    logic [8:0] got;
    logic [8:0] exp;
    logic [8:0] exact;
    int         acc0;
    int         out0;
    int         guard;
    acc0 = acc_cnt;
    out0 = out_cnt;
    for (int n = 0; n < 1000; n++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      bus.op_a = a; bus.op_b = b; bus.op_cin = cin; bus.approx_en = en;
      bus.in_valid = 1'b1;
      exp_q.push_back(ref_add(a, b, cin, en));
      if (!en) begin
        exact = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        n_checks++;
        if (exp_q[$] !== exact) begin
          n_fail++; $display("FAIL model_exact a=%h b=%h cin=%b got=%h exp=%h", a, b, cin, exp_q[$], exact);
        end
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op_a = 8'($urandom_range(0, 255)); bus.op_b = 8'($urandom_range(0, 255));
      bus.op_cin = ~cin; bus.approx_en = ~en;
      guard = 0;
      while (!bus.out_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      got = {bus.cout, bus.sum};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL random_%0d a=%h b=%h cin=%b en=%b got ov=%b res=%h exp=%h",
                           n, a, b, cin, en, bus.out_valid, got, exp);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (acc_cnt - acc0 !== 1000 || out_cnt - out0 !== 1000 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL handshake_count got acc=%0d out=%0d left=%0d exp 1000 1000 0",
                         acc_cnt - acc0, out_cnt - out0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_approx_add();
    test_carry_cutoff();
    test_carry_in();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
